// File: rtl/cmd_rsp_pkg.sv
// Shared types and parameter defaults for the command/response handshake engine.
package cmd_rsp_pkg;

  typedef enum logic [1:0] {
    RECOVER,
    IDLE,
    RESP
  } state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BEATS = 4;
  localparam int DEF_TIMEOUT   = 16;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/wait_timer.sv
// Per-beat stall timer: counts down from TIMEOUT-1 while enabled, reloads on clear.
module wait_timer
  import cmd_rsp_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_cnt
      localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [TW-1:0] START = TW'(TIMEOUT - 1);

      logic [TW-1:0] remain;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          remain <= START;
        end else if (clr) begin
          remain <= START;
        end else if (en && (remain != '0)) begin
          remain <= remain - TW'(1);
        end
      end

      // remain==0 is the same condition as an up-count of stalls reaching TIMEOUT-1
      assign expire = (remain == '0);
    end
  endgenerate

endmodule

// File: rtl/cmd_rsp_fsm.sv
// Command/response engine: one command in, a burst of 1..MAX_BEATS incrementing beats out.
module cmd_rsp_fsm
  import cmd_rsp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int LEN_W     = $clog2(MAX_BEATS),
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  done_cnt
);

  state_e            state, state_n;
  logic [DATA_W-1:0] base, base_n;
  logic [LEN_W-1:0]  len, len_n;
  logic [LEN_W-1:0]  beat, beat_n;
  logic              cmd_rdy_n, rsp_vld_n, rsp_last_n, busy_n, timeout_err_n;
  logic [DATA_W-1:0] rsp_data_n;
  logic [CNT_W-1:0]  done_cnt_n;

  logic stall, expire;

  assign stall = (state == RESP) && rsp_vld && !rsp_rdy;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (!stall),
    .en    (stall),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RECOVER;
      base        <= '0;
      len         <= '0;
      beat        <= '0;
      cmd_rdy     <= 1'b0;
      rsp_vld     <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      done_cnt    <= '0;
    end else begin
      state       <= state_n;
      base        <= base_n;
      len         <= len_n;
      beat        <= beat_n;
      cmd_rdy     <= cmd_rdy_n;
      rsp_vld     <= rsp_vld_n;
      rsp_data    <= rsp_data_n;
      rsp_last    <= rsp_last_n;
      busy        <= busy_n;
      timeout_err <= timeout_err_n;
      done_cnt    <= done_cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    base_n        = base;
    len_n         = len;
    beat_n        = beat;
    cmd_rdy_n     = cmd_rdy;
    rsp_vld_n     = rsp_vld;
    rsp_data_n    = rsp_data;
    rsp_last_n    = rsp_last;
    busy_n        = busy;
    timeout_err_n = 1'b0;
    done_cnt_n    = done_cnt;

    unique case (state)
      RECOVER: begin
        cmd_rdy_n = 1'b1;
        state_n   = IDLE;
      end

      IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          base_n     = cmd_data;
          len_n      = cmd_len;
          beat_n     = '0;
          cmd_rdy_n  = 1'b0;
          rsp_vld_n  = 1'b1;
          rsp_data_n = cmd_data;
          rsp_last_n = (cmd_len == '0);
          busy_n     = 1'b1;
          state_n    = RESP;
        end
      end

      RESP: begin
        if (rsp_vld && rsp_rdy) begin
          if (rsp_last) begin
            rsp_vld_n  = 1'b0;
            rsp_last_n = 1'b0;
            busy_n     = 1'b0;
            done_cnt_n = done_cnt + CNT_W'(1);
            state_n    = RECOVER;
          end else begin
            beat_n     = beat + LEN_W'(1);
            rsp_data_n = base + DATA_W'(beat) + DATA_W'(1);
            rsp_last_n = ((beat + LEN_W'(1)) == len);
          end
        end else if (stall && expire) begin
          rsp_vld_n     = 1'b0;
          rsp_last_n    = 1'b0;
          busy_n        = 1'b0;
          timeout_err_n = 1'b1;
          state_n       = RECOVER;
        end
      end

      default: state_n = RECOVER;
    endcase
  end

endmodule

// File: tb/tb_cmd_rsp_fsm.sv
// Directed bench for cmd_rsp_fsm: vector table of full-speed bursts plus hand-written corner sequences.
module tb_cmd_rsp_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [7:0]  cmd_data;
  logic [1:0]  cmd_len;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        timeout_err;
  logic [15:0] done_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_done = 0;

  always #5 clk = ~clk;

  cmd_rsp_fsm #(
    .DATA_W   (8),
    .MAX_BEATS(4),
    .TIMEOUT  (4),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_data   (cmd_data),
    .cmd_len    (cmd_len),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .busy       (busy),
    .timeout_err(timeout_err),
    .done_cnt   (done_cnt)
  );

  typedef struct {
    logic [7:0]      data;
    logic [1:0]      len;
    logic [3:0][7:0] exp;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd_rdy();
    int unsigned n = 0;
    while (!cmd_rdy && n < 10) begin
      step();
      n++;
    end
    check("cmd_rdy_wait", {31'd0, cmd_rdy}, 32'd1);
  endtask

  // Issue one command; on return the first beat is on the bus.
  task automatic issue(input logic [7:0] d, input logic [1:0] l);
    wait_cmd_rdy();
    cmd_vld  = 1'b1;
    cmd_data = d;
    cmd_len  = l;
    step();
    cmd_vld  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{data: 8'h10, len: 2'd0, exp: {8'h00, 8'h00, 8'h00, 8'h10}};
    vecs[1] = '{data: 8'hFE, len: 2'd3, exp: {8'h01, 8'h00, 8'hFF, 8'hFE}};
    vecs[2] = '{data: 8'h20, len: 2'd1, exp: {8'h00, 8'h00, 8'h21, 8'h20}};
    vecs[3] = '{data: 8'h7F, len: 2'd2, exp: {8'h00, 8'h81, 8'h80, 8'h7F}};

    rst = 1'b1; cmd_vld = 1'b1; cmd_data = 8'h10; cmd_len = 2'd0; rsp_rdy = 1'b1;
    step(); step();
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_done_cnt", {16'd0, done_cnt}, 32'd0);

    // First command straight out of reset, cmd_vld already high.
    rst = 1'b0;
    step();
    check("rel_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    check("rel_rsp_vld", {31'd0, rsp_vld}, 32'd0);
    step();
    cmd_vld = 1'b0;
    check("first_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    check("first_rsp_data", {24'd0, rsp_data}, 32'h10);
    check("first_rsp_last", {31'd0, rsp_last}, 32'd1);
    check("first_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    step();
    exp_done++;
    check("first_done_cnt", {16'd0, done_cnt}, exp_done);
    check("first_recover_rdy", {31'd0, cmd_rdy}, 32'd0);
    step();
    check("first_rdy_again", {31'd0, cmd_rdy}, 32'd1);

    // Full-speed bursts from the vector table.
    rsp_rdy = 1'b1;
    for (int v = 0; v < 4; v++) begin
      issue(vecs[v].data, vecs[v].len);
      for (int i = 0; i <= int'(vecs[v].len); i++) begin
        check("tbl_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        check("tbl_busy", {31'd0, busy}, 32'd1);
        check("tbl_rsp_data", {24'd0, rsp_data}, {24'd0, vecs[v].exp[i]});
        check("tbl_rsp_last", {31'd0, rsp_last}, (i == int'(vecs[v].len)) ? 32'd1 : 32'd0);
        step();
      end
      exp_done++;
      check("tbl_end_vld", {31'd0, rsp_vld}, 32'd0);
      check("tbl_end_busy", {31'd0, busy}, 32'd0);
      check("tbl_done_cnt", {16'd0, done_cnt}, exp_done);
    end

    // Stalled burst: rsp_rdy pattern 0,1,0,0,1,1 with data held during stalls.
    begin
      logic [5:0] rdy_pat;
      logic [5:0][7:0] dat_pat;
      logic [5:0] last_pat;
      rdy_pat  = 6'b110010;
      dat_pat  = {8'h42, 8'h41, 8'h41, 8'h41, 8'h40, 8'h40};
      last_pat = 6'b100000;
      issue(8'h40, 2'd2);
      for (int i = 0; i < 6; i++) begin
        rsp_rdy = rdy_pat[i];
        check("stall_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        check("stall_rsp_data", {24'd0, rsp_data}, {24'd0, dat_pat[i]});
        check("stall_rsp_last", {31'd0, rsp_last}, {31'd0, last_pat[i]});
        check("stall_no_to", {31'd0, timeout_err}, 32'd0);
        step();
      end
      exp_done++;
      check("stall_done_cnt", {16'd0, done_cnt}, exp_done);
      check("stall_no_to_end", {31'd0, timeout_err}, 32'd0);
    end

    // Timeout abort after 4 stall cycles.
    rsp_rdy = 1'b0;
    issue(8'h55, 2'd1);
    for (int i = 0; i < 4; i++) begin
      check("to_rsp_vld", {31'd0, rsp_vld}, 32'd1);
      check("to_rsp_data", {24'd0, rsp_data}, 32'h55);
      check("to_err_low", {31'd0, timeout_err}, 32'd0);
      step();
    end
    check("to_vld_drop", {31'd0, rsp_vld}, 32'd0);
    check("to_err_pulse", {31'd0, timeout_err}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_done_cnt", {16'd0, done_cnt}, exp_done);
    step();
    check("to_err_clear", {31'd0, timeout_err}, 32'd0);
    check("to_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

    // Handshake on the 4th stall edge beats the abort; the wait counter restarts per beat.
    rsp_rdy = 1'b0;
    issue(8'h60, 2'd1);
    step(); step(); step();
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    check("edge_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    check("edge_rsp_data", {24'd0, rsp_data}, 32'h61);
    check("edge_rsp_last", {31'd0, rsp_last}, 32'd1);
    check("edge_no_to", {31'd0, timeout_err}, 32'd0);
    step(); step(); step();
    check("edge2_rsp_vld", {31'd0, rsp_vld}, 32'd1);
    check("edge2_no_to", {31'd0, timeout_err}, 32'd0);
    rsp_rdy = 1'b1;
    step();
    exp_done++;
    check("edge_done_cnt", {16'd0, done_cnt}, exp_done);
    check("edge_end_no_to", {31'd0, timeout_err}, 32'd0);

    // cmd_vld held through a burst is ignored until RECOVER->IDLE.
    rsp_rdy = 1'b0;
    issue(8'h30, 2'd1);
    cmd_vld = 1'b1; cmd_data = 8'hAA; cmd_len = 2'd0;
    step();
    check("ign_rsp_data0", {24'd0, rsp_data}, 32'h30);
    rsp_rdy = 1'b1;
    step();
    check("ign_rsp_data1", {24'd0, rsp_data}, 32'h31);
    step();
    exp_done++;
    check("ign_recover_vld", {31'd0, rsp_vld}, 32'd0);
    step();
    check("ign_idle_vld", {31'd0, rsp_vld}, 32'd0);
    step();
    cmd_vld = 1'b0;
    check("ign_new_vld", {31'd0, rsp_vld}, 32'd1);
    check("ign_new_data", {24'd0, rsp_data}, 32'hAA);
    check("ign_new_last", {31'd0, rsp_last}, 32'd1);
    step();
    exp_done++;
    check("ign_done_cnt", {16'd0, done_cnt}, exp_done);

    // Asynchronous reset in the middle of a burst.
    rsp_rdy = 1'b1;
    issue(8'h70, 2'd3);
    step();
    check("mid_rsp_data", {24'd0, rsp_data}, 32'h71);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'd0, rsp_vld}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", {24'd0, rsp_data}, 32'd0);
    check("mid_rst_last", {31'd0, rsp_last}, 32'd0);
    check("mid_rst_done", {16'd0, done_cnt}, 32'd0);
    check("mid_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
